// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the 16 x 32-bit register file write port.
// Buffers pipeline writeback requests in an in-order queue and drains them
// one per cycle into a registered output stage that drives the register file.
// Pending write data is forwarded onto both operand read paths.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   wb_valid/wb_ready      writeback request handshake
//   wb_addr/wb_data        writeback destination register and value
//   drain_en               register file write port granted this cycle
//   rf_write/addr/data     registered register file write port
//   rd_addr_a/rd_addr_b    operand read addresses
//   rf_data_a/rf_data_b    register file read data
//   op_a/op_b              forwarded operands
//   count                  queued entries, not counting the output stage
module regfile_wb_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     drain_en,
  output logic                     rf_write,
  output logic [ADDR_W-1:0]        rf_addr,
  output logic [DATA_W-1:0]        rf_data,
  input  logic [ADDR_W-1:0]        rd_addr_a,
  input  logic [ADDR_W-1:0]        rd_addr_b,
  input  logic [DATA_W-1:0]        rf_data_a,
  input  logic [DATA_W-1:0]        rf_data_b,
  output logic [DATA_W-1:0]        op_a,
  output logic [DATA_W-1:0]        op_b,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_addr_mem [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_rf_write;
  logic [ADDR_W-1:0] r_rf_addr;
  logic [DATA_W-1:0] r_rf_data;

  logic              w_xfer;
  logic              w_pop;
  logic              w_fall;
  logic              w_push;
  logic              w_empty;
  logic [PTR_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;

  assign w_empty  = (r_count == '0);
  assign wb_ready = (r_count != CNT_W'(DEPTH));
  assign w_xfer   = wb_valid && wb_ready;
  assign w_pop    = drain_en && !w_empty;
  // Empty queue with the port granted: the request bypasses storage.
  assign w_fall   = drain_en && w_empty && w_xfer;
  assign w_push   = w_xfer && !w_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rf_write <= 1'b0;
      r_rf_addr  <= '0;
      r_rf_data  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_rf_write <= 1'b1;
        r_rf_addr  <= r_addr_mem[r_rptr];
        r_rf_data  <= r_data_mem[r_rptr];
      end else if (w_fall) begin
        r_rf_write <= 1'b1;
        r_rf_addr  <= wb_addr;
        r_rf_data  <= wb_data;
      end else begin
        r_rf_write <= 1'b0;
      end
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_mem[r_wptr] <= wb_addr;
      r_data_mem[r_wptr] <= wb_data;
    end
  end

  // Lowest priority first; the queue scan walks oldest to youngest so the
  // youngest matching entry wins.
  always_comb begin
    w_op_a = rf_data_a;
    w_op_b = rf_data_b;
    w_idx  = r_rptr;
    if (r_rf_write && (r_rf_addr == rd_addr_a)) w_op_a = r_rf_data;
    if (r_rf_write && (r_rf_addr == rd_addr_b)) w_op_b = r_rf_data;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = r_rptr + PTR_W'(i);
      if (CNT_W'(i) < r_count) begin
        if (r_addr_mem[w_idx] == rd_addr_a) w_op_a = r_data_mem[w_idx];
        if (r_addr_mem[w_idx] == rd_addr_b) w_op_b = r_data_mem[w_idx];
      end
    end
  end

  assign op_a     = w_op_a;
  assign op_b     = w_op_b;
  assign rf_write = r_rf_write;
  assign rf_addr  = r_rf_addr;
  assign rf_data  = r_rf_data;
  assign count    = r_count;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed vectors, expected register file writes
// queued by the stimulus and checked by an independent write-port monitor.
module tb_regfile_wb_queue;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              drain_en;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rf_data_a;
  logic [DATA_W-1:0] rf_data_b;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [2:0]        count;

  regfile_wb_queue #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .drain_en (drain_en),
    .rf_write (rf_write),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .rf_data_a(rf_data_a),
    .rf_data_b(rf_data_b),
    .op_a     (op_a),
    .op_b     (op_b),
    .count    (count)
  );

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] rf_mem  [16];
  logic [31:0] ref_mem [16];
  int          total   = 0;
  int          bad     = 0;
  int          nwrites = 0;

  logic [3:0]  v_a [12] = '{4'd2, 4'd2, 4'd5, 4'd0, 4'd15, 4'd2,
                            4'd7, 4'd5, 4'd0, 4'd11, 4'd2, 4'd14};
  logic [31:0] v_d [12] = '{32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106,
                            32'h107, 32'h108, 32'h109, 32'h10A, 32'h10B, 32'h10C};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  task automatic expect_wr(input logic [3:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
    ref_mem[a] = d;
  endtask

  // Write-port monitor: also acts as the register file, committing on the falling edge.
  always @(negedge clk) begin
    if (!rst && rf_write) begin
      wr_t e;
      nwrites++;
      rf_mem[rf_addr] = rf_data;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %h data %h want none", rf_addr, rf_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(rf_addr), 32'(e.a));
        check("wr_data", rf_data, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int cyc;
    int nw0;
    rst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; drain_en = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0; rf_data_a = '0; rf_data_b = '0;
    for (int i = 0; i < 16; i++) begin
      rf_mem[i]  = '0;
      ref_mem[i] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_write", 32'(rf_write), 32'd0);
    check("rst_addr",  32'(rf_addr),  32'd0);
    check("rst_data",  rf_data,       32'd0);
    check("rst_count", 32'(count),    32'd0);
    check("rst_ready", 32'(wb_ready), 32'd1);
    rst = 1'b0;

    // Fall-through with the port granted and an empty queue.
    wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 32'hAA; drain_en = 1'b1;
    expect_wr(4'd3, 32'hAA);
    @(negedge clk);
    check("t1_write", 32'(rf_write), 32'd1);
    check("t1_addr",  32'(rf_addr),  32'd3);
    check("t1_data",  rf_data,       32'hAA);
    check("t1_count", 32'(count),    32'd0);
    wb_valid = 1'b0;
    @(negedge clk);
    check("t1_idle",   32'(rf_write), 32'd0);
    check("t1_count2", 32'(count),    32'd0);

    // Fill to full, stall the fifth, then drain in order.
    drain_en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      wb_valid = 1'b1; wb_addr = 4'(k); wb_data = 32'(k * 17);
      expect_wr(4'(k), 32'(k * 17));
      if (k < 5) @(negedge clk);
    end
    @(negedge clk);
    check("t2_full_count", 32'(count),    32'd4);
    check("t2_full_ready", 32'(wb_ready), 32'd0);
    check("t2_no_write",   32'(rf_write), 32'd0);
    drain_en = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("t2_drain_pulse", 32'(rf_write), 32'd1);
      if (j == 0) check("t2_ready_rise", 32'(wb_ready), 32'd1);
      if (j == 1) wb_valid = 1'b0;
    end
    @(negedge clk);
    check("t2_end_write", 32'(rf_write), 32'd0);
    check("t2_end_count", 32'(count),    32'd0);

    // Forwarding of repeated writes to the same register.
    drain_en = 1'b0; rd_addr_a = 4'd9; rf_data_a = 32'hDEAD;
    wb_valid = 1'b1; wb_addr = 4'd9; wb_data = 32'h1;
    expect_wr(4'd9, 32'h1);
    @(negedge clk);
    wb_data = 32'h2;
    expect_wr(4'd9, 32'h2);
    #1;
    check("t3_excl_wb", op_a, 32'h1);
    @(negedge clk);
    wb_valid = 1'b0;
    check("t3_count", 32'(count), 32'd2);
    check("t3_young", op_a, 32'h2);
    drain_en = 1'b1;
    @(negedge clk);
    check("t3_one_drained", op_a, 32'h2);
    @(negedge clk);
    check("t3_out_stage", op_a, 32'h2);
    @(negedge clk);
    check("t3_rf_path", op_a, 32'hDEAD);
    rf_data_a = 32'h1234;
    #1;
    check("t3_rf_follow", op_a, 32'h1234);

    // Output-stage forwarding to register 0 on port B.
    rd_addr_b = 4'd0; rf_data_b = 32'h0;
    wb_valid = 1'b1; wb_addr = 4'd0; wb_data = 32'h77;
    expect_wr(4'd0, 32'h77);
    @(negedge clk);
    check("t4_write", 32'(rf_write), 32'd1);
    check("t4_op_b",  op_b,          32'h77);
    wb_valid = 1'b0;
    @(negedge clk);

    // Asynchronous reset with entries queued and a write in flight.
    drain_en = 1'b0;
    wb_valid = 1'b1; wb_addr = 4'd6; wb_data = 32'h66;
    expect_wr(4'd6, 32'h66);
    @(negedge clk); wb_addr = 4'd7;  wb_data = 32'h67;
    @(negedge clk); wb_addr = 4'd8;  wb_data = 32'h68;
    @(negedge clk); wb_addr = 4'd10; wb_data = 32'h6A;
    @(negedge clk);
    wb_valid = 1'b0; drain_en = 1'b1;
    check("t5_full", 32'(count), 32'd4);
    @(negedge clk);
    check("t5_count3", 32'(count),    32'd3);
    check("t5_inflt",  32'(rf_write), 32'd1);
    drain_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_write", 32'(rf_write), 32'd0);
    check("t5_rst_addr",  32'(rf_addr),  32'd0);
    check("t5_rst_data",  rf_data,       32'd0);
    check("t5_rst_count", 32'(count),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    wb_valid = 1'b1; wb_addr = 4'd15; wb_data = 32'hF00D;
    expect_wr(4'd15, 32'hF00D);
    nw0 = nwrites;
    @(negedge clk);
    wb_valid = 1'b0;
    check("t5_push_count", 32'(count), 32'd1);
    drain_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("t5_single_write", 32'(nwrites - nw0), 32'd1);
    check("t5_end_count",    32'(count),         32'd0);

    // Back-to-back pushes with the write port granted every other cycle.
    @(negedge clk);
    idx = 0;
    cyc = 0;
    while (idx < 12 && cyc < 200) begin
      wb_valid = 1'b1; wb_addr = v_a[idx]; wb_data = v_d[idx];
      drain_en = (cyc % 2 == 0);
      if (wb_ready) begin
        expect_wr(v_a[idx], v_d[idx]);
        idx++;
      end
      @(negedge clk);
      check("t6_count_bound", 32'(count <= 3'(DEPTH)), 32'd1);
      cyc++;
    end
    check("t6_all_issued", 32'(idx), 32'd12);
    wb_valid = 1'b0; drain_en = 1'b1;
    for (int t = 0; t < 20 && !(count == 0 && !rf_write); t++) @(negedge clk);
    check("t6_drained_count", 32'(count),    32'd0);
    check("t6_drained_write", 32'(rf_write), 32'd0);
    @(negedge clk);
    #1;
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    for (int r = 0; r < 16; r++) check("t6_regfile", rf_mem[r], ref_mem[r]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Writer-side front end for the 16-entry, 32-bit register file.
- Accepts writeback requests from the pipeline and buffers them in a small in-order queue.
- Drives the register file's single write port (write / save-address / data) one entry per cycle.
- Forwards still-pending write data onto the two operand read paths, so readers never see a stale value.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 4, register address width (16 registers: 0-7 = $s0-$s7, 8-15 = $t0-$t7; no hard-wired zero register).
- DEPTH, 4, queue entries (power of two, at least 2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wb_valid  in  1  writeback request present.
- wb_ready  out  1  queue can accept a request this cycle.
- wb_addr  in  ADDR_W  destination register of the request.
- wb_data  in  DATA_W  value to write.
- drain_en  in  1  write port granted to this block this cycle.
- rf_write  out  1  to register file write enable.
- rf_addr  out  ADDR_W  to register file save address.
- rf_data  out  DATA_W  to register file write data.
- rd_addr_a  in  ADDR_W  operand A address (also driven to the register file A address).
- rd_addr_b  in  ADDR_W  operand B address.
- rf_data_a  in  DATA_W  register file A read data.
- rf_data_b  in  DATA_W  register file B read data.
- op_a  out  DATA_W  forwarded operand A.
- op_b  out  DATA_W  forwarded operand B.
- count  out  $clog2(DEPTH)+1  number of queued entries, excluding the output stage.

Behaviour:
- Reset (async, any time): count=0, rd/wr pointers=0, rf_write=0, rf_addr=0, rf_data=0. All queued and in-flight writes are discarded. The first request after reset release is accepted normally.
- Handshake:
  - wb_ready = (count != DEPTH), combinational from count only.
  - Transfer occurs on a rising edge with wb_valid && wb_ready.
  - wb_valid while full: request held off, nothing lost or duplicated.
- Output stage is registered; rf_write is asserted for exactly one cycle per entry.
- Timing with the register file: rf_* change on the rising edge and are stable at the following falling edge, where the register file commits.
- Each rising edge, in this order:
  - If drain_en=1 and count>0: pop the queue head into rf_addr/rf_data and set rf_write=1.
  - Else if drain_en=1, count=0 and a transfer occurs: fall-through, the incoming request loads rf_* directly with rf_write=1 and count is unchanged (1-cycle latency).
  - Else: rf_write=0; rf_addr/rf_data hold their values.
  - A transfer not consumed by fall-through is pushed at the tail.
  - Simultaneous push and pop: count unchanged, pointers both advance.
- Ordering: strictly FIFO, including repeated writes to the same address; no coalescing.
- Pointers wrap modulo DEPTH.
- Forwarding (combinational), op_a (op_b identical with rd_addr_b/rf_data_b). Priority:
  1. Youngest valid queue entry with addr == rd_addr_a.
  2. Otherwise the output stage, if rf_write=1 and rf_addr == rd_addr_a (covers the half-cycle before the falling-edge commit).
  3. Otherwise rf_data_a.
- Forwarding excludes the request being presented on wb_* in the same cycle.
- Address 0 is an ordinary register and is forwarded like any other.

Test Plan:
- Reset, then wb_valid=1, addr=3, data=0x0000_00AA, drain_en=1 at edge 1 -> after edge 1 rf_write=1, rf_addr=3, rf_data=0xAA; after edge 2 rf_write=0; count stays 0 throughout.
- drain_en=0, push addr=1..5 with data=0x11..0x55 -> first 4 accepted, count=4, wb_ready=0, addr 5 stalled. Then drain_en=1 -> rf_write pulses on 5 consecutive edges with addr 1,2,3,4,5 in order; wb_ready rises after the first pop.
- drain_en=0, push addr=9 data=0x1, then addr=9 data=0x2; rd_addr_a=9, rf_data_a=0xDEAD -> op_a=0x2. Drain one entry -> op_a still 0x2. Drain both -> op_a follows rf_data_a.
- rf_write=1 with rf_addr=0, rf_data=0x77, queue empty, rd_addr_b=0, rf_data_b=0 -> op_b=0x77 in that cycle.
- Queue count=3, assert rst asynchronously mid-cycle -> rf_write, rf_addr, rf_data and count go to 0 immediately without a clock edge. After release, a new push to addr=15 drains as the only write.
- Continuous push at 1/cycle with drain_en toggling 1,0,1,0 -> no loss, order preserved, count never exceeds DEPTH, final register file contents match a reference model.
